// File: rtl/mvm_arb_pkg.sv
// Shared types and sizing helpers for the matrix-vector job arbiter.
//
// Contents:
//   arb_state_e  - arbiter FSM state (idle / feeding the engine / draining results)
//   DefM, DefN   - default matrix shape (3x3)
//   job_in_len   - words per job on the input side: M*N matrix words then N vector words
//   job_out_len  - results per job on the output side: one per matrix row
//   cnt_width    - bits needed to count 0..n inclusive
package mvm_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFeed  = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

  localparam int unsigned DefM = 3;
  localparam int unsigned DefN = 3;

  function automatic int unsigned job_in_len(input int unsigned m, input int unsigned n);
    return m * n + n;
  endfunction

  function automatic int unsigned job_out_len(input int unsigned m);
    return m;
  endfunction

  // Counters run all the way to the job length, so they need room for n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection, purely combinational.
//
// Ports:
//   i_req         - request vector, bit k = port k has a word waiting
//   i_last_grant  - port that owned the most recently completed job
//   o_grant_valid - at least one request is present
//   o_grant       - selected port index (0 when nothing is requested)
//
// On contention the port that did not win last time is picked, so two
// persistent requesters strictly alternate.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant_valid,
  output logic       o_grant
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant       = 1'b0;
    unique case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mvm_job_arbiter.sv
// Job-granular arbiter sharing one MxN matrix-vector engine between two
// requesters. A granted requester streams a whole job (M*N matrix words
// row-major, then N vector words) straight into the engine; the engine's M
// row results are then routed back to that same requester. The grant is held
// for the entire job and alternates round-robin under contention.
//
// Ports:
//   i_clk, i_rst_n            - clock, asynchronous active-low reset
//   i_reqK_valid/data         - requester K input word stream
//   o_reqK_ready              - requester K word accepted
//   o_rspK_valid/data         - result stream back to requester K
//   i_rspK_ready              - requester K accepts result
//   o_eng_in_valid/data       - to engine input port
//   i_eng_in_ready            - from engine input port
//   i_eng_out_valid/data      - from engine output port
//   o_eng_out_ready           - to engine output port
//   o_busy                    - a job is in progress
//   o_owner                   - current or most recently granted port
//   o_job_done                - one-cycle pulse the cycle after the last result handshake
module mvm_job_arbiter
  import mvm_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned OUT_WIDTH = 28,
  parameter int unsigned M         = DefM,
  parameter int unsigned N         = DefN
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,

  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [WIDTH-1:0]     i_req0_data,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [WIDTH-1:0]     i_req1_data,

  output logic                 o_rsp0_valid,
  input  logic                 i_rsp0_ready,
  output logic [OUT_WIDTH-1:0] o_rsp0_data,
  output logic                 o_rsp1_valid,
  input  logic                 i_rsp1_ready,
  output logic [OUT_WIDTH-1:0] o_rsp1_data,

  output logic                 o_eng_in_valid,
  input  logic                 i_eng_in_ready,
  output logic [WIDTH-1:0]     o_eng_in_data,
  input  logic                 i_eng_out_valid,
  output logic                 o_eng_out_ready,
  input  logic [OUT_WIDTH-1:0] i_eng_out_data,

  output logic                 o_busy,
  output logic                 o_owner,
  output logic                 o_job_done
);

  localparam int unsigned JobIn   = job_in_len(M, N);
  localparam int unsigned JobOut  = job_out_len(M);
  localparam int unsigned InCntW  = cnt_width(JobIn);
  localparam int unsigned OutCntW = cnt_width(JobOut);

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic                r_owner;
  logic                w_owner_nxt;
  logic                r_last_grant;
  logic                w_last_grant_nxt;
  logic [InCntW-1:0]   r_in_cnt;
  logic [InCntW-1:0]   w_in_cnt_nxt;
  logic [OutCntW-1:0]  r_out_cnt;
  logic [OutCntW-1:0]  w_out_cnt_nxt;
  logic                r_job_done;
  logic                w_job_done_nxt;

  logic [1:0]          w_req_valid;
  logic                w_grant_valid;
  logic                w_grant;
  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_in_last;
  logic                w_out_last;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  assign w_req_valid = {i_req1_valid, i_req0_valid};

  rr_arbiter2 u_rr_arbiter2 (
    .i_req         (w_req_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  // Handshakes are only possible in their own phase because the steering
  // below forces the relevant valid/ready low everywhere else.
  assign w_in_hs    = o_eng_in_valid & i_eng_in_ready;
  assign w_out_hs   = i_eng_out_valid & o_eng_out_ready;
  assign w_in_last  = (r_in_cnt == InCntW'(JobIn - 1));
  assign w_out_last = (r_out_cnt == OutCntW'(JobOut - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;   // port 0 wins the first tie
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_job_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_in_cnt     <= w_in_cnt_nxt;
      r_out_cnt    <= w_out_cnt_nxt;
      r_job_done   <= w_job_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_in_cnt_nxt     = r_in_cnt;
    w_out_cnt_nxt    = r_out_cnt;
    w_job_done_nxt   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_grant_valid) begin
          w_owner_nxt  = w_grant;
          w_in_cnt_nxt = '0;
          w_state_nxt  = StFeed;
        end
      end

      StFeed: begin
        // Stalls simply leave the count where it is.
        if (w_in_hs) begin
          w_in_cnt_nxt = r_in_cnt + InCntW'(1);
          if (w_in_last) begin
            w_out_cnt_nxt = '0;
            w_state_nxt   = StDrain;
          end
        end
      end

      StDrain: begin
        if (w_out_hs) begin
          w_out_cnt_nxt = r_out_cnt + OutCntW'(1);
          if (w_out_last) begin
            w_last_grant_nxt = r_owner;
            w_job_done_nxt   = 1'b1;
            w_state_nxt      = StIdle;
          end
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Steering muxes: zero-latency pass-through between owner and engine
  // ---------------------------------------------------------------------------
  always_comb begin
    o_eng_in_valid  = 1'b0;
    o_eng_in_data   = '0;
    o_req0_ready    = 1'b0;
    o_req1_ready    = 1'b0;
    o_eng_out_ready = 1'b0;
    o_rsp0_valid    = 1'b0;
    o_rsp1_valid    = 1'b0;
    o_rsp0_data     = '0;
    o_rsp1_data     = '0;

    unique case (r_state)
      StFeed: begin
        o_eng_in_valid = r_owner ? i_req1_valid : i_req0_valid;
        o_eng_in_data  = r_owner ? i_req1_data : i_req0_data;
        o_req0_ready   = ~r_owner & i_eng_in_ready;
        o_req1_ready   = r_owner & i_eng_in_ready;
      end

      StDrain: begin
        // Engine output is only acknowledged here, so early results wait in
        // the engine rather than being lost.
        o_eng_out_ready = r_owner ? i_rsp1_ready : i_rsp0_ready;
        o_rsp0_valid    = ~r_owner & i_eng_out_valid;
        o_rsp1_valid    = r_owner & i_eng_out_valid;
        o_rsp0_data     = r_owner ? '0 : i_eng_out_data;
        o_rsp1_data     = r_owner ? i_eng_out_data : '0;
      end

      default: begin
      end
    endcase
  end

  assign o_busy     = (r_state != StIdle);
  assign o_owner    = r_owner;
  assign o_job_done = r_job_done;

endmodule

// File: tb/tb_mvm_job_arbiter.sv
// Scoreboard bench: stimulus pushes request words and expected results into
// queues; a negedge monitor checks every handshake against a job-level model
// (12 words in from one port, then 3 results back to that port).
module tb_mvm_job_arbiter;

  localparam int unsigned WIDTH     = 14;
  localparam int unsigned OUT_WIDTH = 28;
  localparam int JobIn  = 12;
  localparam int JobOut = 3;

  typedef logic [WIDTH-1:0]     word_t;
  typedef logic [OUT_WIDTH-1:0] res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic  req0_valid, req1_valid, req0_ready, req1_ready;
  word_t req0_data, req1_data;
  logic  rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  res_t  rsp0_data, rsp1_data;
  logic  eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;
  word_t eng_in_data;
  res_t  eng_out_data;
  logic  o_busy, o_owner, o_job_done;

  mvm_job_arbiter #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .M         (3),
    .N         (3)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req0_valid    (req0_valid),
    .o_req0_ready    (req0_ready),
    .i_req0_data     (req0_data),
    .i_req1_valid    (req1_valid),
    .o_req1_ready    (req1_ready),
    .i_req1_data     (req1_data),
    .o_rsp0_valid    (rsp0_valid),
    .i_rsp0_ready    (rsp0_ready),
    .o_rsp0_data     (rsp0_data),
    .o_rsp1_valid    (rsp1_valid),
    .i_rsp1_ready    (rsp1_ready),
    .o_rsp1_data     (rsp1_data),
    .o_eng_in_valid  (eng_in_valid),
    .i_eng_in_ready  (eng_in_ready),
    .o_eng_in_data   (eng_in_data),
    .i_eng_out_valid (eng_out_valid),
    .o_eng_out_ready (eng_out_ready),
    .i_eng_out_data  (eng_out_data),
    .o_busy          (o_busy),
    .o_owner         (o_owner),
    .o_job_done      (o_job_done)
  );

  initial forever #5 clk = ~clk;

  // Scoreboard state
  word_t req_q0[$], req_q1[$];
  res_t  exp_q0[$], exp_q1[$];
  res_t  eng_q[$];
  int    exp_owner_q[$];
  word_t ebuf[12];
  int    words_in = 0, words_out = 0, job_port = 0;
  bit    done_pending = 0, skip_compute = 0, armed = 0;
  int    done_cnt = 0, hold_cnt = 0;
  int    bubble = 0;
  int    n_checks = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit roll();
    return $urandom_range(99) >= bubble;
  endfunction

  // Reference engine: y[r] = sum_j W[r][j] * x[j], signed, truncated to OUT_WIDTH.
  function automatic res_t row_dot(input word_t job[12], input int r);
    longint acc;
    acc = 0;
    for (int j = 0; j < 3; j++)
      acc += longint'($signed(job[r*3+j])) * longint'($signed(job[9+j]));
    return res_t'(acc);
  endfunction

  task automatic push_exp(input int p, input int y0, input int y1, input int y2);
    if (p == 1) begin
      exp_q1.push_back(res_t'(y0)); exp_q1.push_back(res_t'(y1)); exp_q1.push_back(res_t'(y2));
    end else begin
      exp_q0.push_back(res_t'(y0)); exp_q0.push_back(res_t'(y1)); exp_q0.push_back(res_t'(y2));
    end
  endtask

  task automatic push_job(input int p, input int v[12], input bit auto_exp, input bit preload);
    word_t job[12];
    res_t  y;
    for (int i = 0; i < 12; i++) begin
      job[i] = WIDTH'(v[i]);
      if (p == 1) req_q1.push_back(job[i]);
      else        req_q0.push_back(job[i]);
    end
    if (auto_exp) begin
      for (int r = 0; r < 3; r++) begin
        y = row_dot(job, r);
        if (p == 1) exp_q1.push_back(y);
        else        exp_q0.push_back(y);
        if (preload) eng_q.push_back(y);
      end
      if (preload) skip_compute = 1;
    end
  endtask

  task automatic push_random_job(input int p, input bit preload);
    int v[12];
    for (int i = 0; i < 12; i++) v[i] = int'($urandom_range(16383)) - 8192;
    push_job(p, v, 1'b1, preload);
  endtask

  // Stimulus drivers: requesters and engine stub, updated just after each edge.
  initial begin
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    rsp0_ready = 0; rsp1_ready = 0; eng_in_ready = 0; eng_out_valid = 0; eng_out_data = '0;
    forever begin
      @(posedge clk); #1;
      req0_valid    = (req_q0.size() > 0) && roll();
      req0_data     = (req_q0.size() > 0) ? req_q0[0] : '0;
      req1_valid    = (req_q1.size() > 0) && roll();
      req1_data     = (req_q1.size() > 0) ? req_q1[0] : '0;
      eng_in_ready  = roll();
      rsp0_ready    = roll();
      rsp1_ready    = roll();
      eng_out_valid = (eng_q.size() > 0);
      eng_out_data  = (eng_q.size() > 0) ? eng_q[0] : '0;
    end
  end

  // Monitor: evaluates the handshakes that the next rising edge will commit.
  initial begin
    bit in_drain, exp_done;
    int p, q;
    res_t got, want;
    forever begin
      @(negedge clk);
      if (!rst_n || !armed) begin
        words_in = 0; words_out = 0; done_pending = 0; skip_compute = 0;
        eng_q.delete();
      end else begin
        in_drain = (words_in == JobIn);
        exp_done = done_pending;
        done_pending = 0;
        check("job_done", o_job_done, exp_done);
        if (o_job_done) begin
          done_cnt++;
          check("idle_after_done", o_busy, 0);
        end

        if (eng_in_valid && eng_in_ready) begin
          check("in_ready_onehot", req0_ready ^ req1_ready, 1);
          p = req1_ready ? 1 : 0;
          check("in_phase", words_in < JobIn, 1);
          check("in_valid_pass", (p == 1) ? req1_valid : req0_valid, 1);
          check("in_word_pending", (p == 1) ? req_q1.size() : req_q0.size(), 12 - words_in > 0 ?
                ((p == 1) ? req_q1.size() : req_q0.size()) : 0);
          if (p == 1 && req_q1.size() > 0) check("in_data", eng_in_data, req_q1.pop_front());
          else if (p == 0 && req_q0.size() > 0) check("in_data", eng_in_data, req_q0.pop_front());
          if (words_in == 0) begin
            job_port = p;
            check("owner", o_owner, p);
            if (exp_owner_q.size() > 0) check("grant_order", p, exp_owner_q.pop_front());
          end else begin
            check("job_port_stable", p, job_port);
          end
          if (words_in < JobIn) ebuf[words_in] = eng_in_data;
          words_in++;
          if (words_in == JobIn) begin
            if (skip_compute) skip_compute = 0;
            else for (int r = 0; r < 3; r++) eng_q.push_back(row_dot(ebuf, r));
          end
        end

        if (eng_out_valid && !in_drain) begin
          hold_cnt++;
          check("hold_off", eng_out_ready, 0);
        end
        if (in_drain) check("out_ready_pass", eng_out_ready, (job_port == 1) ? rsp1_ready : rsp0_ready);

        if (rsp0_valid || rsp1_valid) begin
          q = rsp1_valid ? 1 : 0;
          check("rsp_onehot", rsp0_valid ^ rsp1_valid, 1);
          check("rsp_phase", in_drain, 1);
          check("rsp_port", q, job_port);
          check("rsp_data_pass", (q == 1) ? rsp1_data : rsp0_data, eng_out_data);
          check("rsp_other_data", (q == 1) ? rsp0_data : rsp1_data, 0);
          if ((q == 1) ? rsp1_ready : rsp0_ready) begin
            got = (q == 1) ? rsp1_data : rsp0_data;
            check("result_expected", ((q == 1) ? exp_q1.size() : exp_q0.size()) > 0, 1);
            if (q == 1 && exp_q1.size() > 0) begin
              want = exp_q1.pop_front(); check("result1", got, want);
            end else if (q == 0 && exp_q0.size() > 0) begin
              want = exp_q0.pop_front(); check("result0", got, want);
            end
            words_out++;
            if (words_out == JobOut) begin
              words_in = 0; words_out = 0; done_pending = 1;
            end
          end
        end

        if (eng_out_valid && eng_out_ready) begin
          check("out_phase", in_drain, 1);
          if (eng_q.size() > 0) void'(eng_q.pop_front());
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_req0_ready"}, req0_ready, 0);
    check({tag, "_req1_ready"}, req1_ready, 0);
    check({tag, "_eng_in_valid"}, eng_in_valid, 0);
    check({tag, "_eng_out_ready"}, eng_out_ready, 0);
    check({tag, "_rsp0_valid"}, rsp0_valid, 0);
    check({tag, "_rsp1_valid"}, rsp1_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_job_done"}, o_job_done, 0);
    check({tag, "_owner"}, o_owner, 0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check_quiet(tag);
    req_q0.delete(); req_q1.delete(); exp_q0.delete(); exp_q1.delete();
    exp_owner_q.delete(); eng_q.delete(); skip_compute = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1;
    armed = 1;
  endtask

  task automatic wait_jobs(input string tag, input int budget);
    int k;
    k = 0;
    while ((req_q0.size() + req_q1.size() + exp_q0.size() + exp_q1.size() != 0 || o_busy)
           && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    check({tag, "_timeout"}, k < budget, 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int d0, h0, k;
    int v[12];

    // Test 1: single job on port 0
    apply_reset("rst0");
    bubble = 0;
    @(posedge clk); #2;
    d0 = done_cnt;
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 1, 1};
    push_job(0, v, 1'b0, 1'b0);
    push_exp(0, 6, 15, 24);
    exp_owner_q.push_back(0);
    wait_jobs("t1", 500);
    check("t1_done_cnt", done_cnt - d0, 1);

    // Test 2: tie at first idle after reset, then port 1 identity job
    apply_reset("rst1");
    @(posedge clk); #2;
    d0 = done_cnt;
    push_random_job(0, 1'b0);
    v = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 5, -3, 7};
    push_job(1, v, 1'b0, 1'b0);
    push_exp(1, 5, -3, 7);
    exp_owner_q.push_back(0);
    exp_owner_q.push_back(1);
    wait_jobs("t2", 1000);
    check("t2_done_cnt", done_cnt - d0, 2);
    check("t2_order_used", exp_owner_q.size(), 0);

    // Test 3: four contending jobs, both ports always valid
    @(posedge clk); #2;
    d0 = done_cnt;
    push_random_job(0, 1'b0);
    push_random_job(1, 1'b0);
    push_random_job(0, 1'b0);
    push_random_job(1, 1'b0);
    for (int i = 0; i < 4; i++) exp_owner_q.push_back(i % 2);
    wait_jobs("t3", 2000);
    check("t3_done_cnt", done_cnt - d0, 4);
    check("t3_order_used", exp_owner_q.size(), 0);

    // Test 4: random 30% bubbles on both sides
    bubble = 30;
    @(posedge clk); #2;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) push_random_job(int'($urandom_range(1)), 1'b0);
    wait_jobs("t4", 8000);
    check("t4_done_cnt", done_cnt - d0, 8);
    bubble = 0;

    // Test 5: reset in the middle of feeding a port 1 job
    @(posedge clk); #2;
    push_random_job(1, 1'b0);
    k = 0;
    while (words_in < 5 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    check("t5_reach_word5", words_in >= 5, 1);
    check("t5_busy_before", o_busy, 1);
    check("t5_owner_before", o_owner, 1);
    apply_reset("t5_abort");
    @(posedge clk); #2;
    d0 = done_cnt;
    push_random_job(1, 1'b0);
    exp_owner_q.push_back(1);
    wait_jobs("t5", 500);
    check("t5_done_cnt", done_cnt - d0, 1);

    // Test 6: engine raises output valid before the job has been fed
    @(posedge clk); #2;
    d0 = done_cnt;
    h0 = hold_cnt;
    push_random_job(0, 1'b1);
    wait_jobs("t6", 500);
    check("t6_done_cnt", done_cnt - d0, 1);
    check("t6_stray_seen", hold_cnt > h0, 1);

    check("final_queues_empty",
          req_q0.size() + req_q1.size() + exp_q0.size() + exp_q1.size() + eng_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard against a hang anywhere in the flow.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mvm_job_arbiter.md
# mvm_job_arbiter

Two-port, job-granular arbiter sharing one 3x3 matrix-vector engine between two independent requesters. Each requester streams one complete job (9 W words row-major, then 3 x words), and the arbiter steers that job into the engine and routes the engine's 3 row results back to the same requester. The block sits between the requester streams and the engine's valid/ready ports. It holds the grant for the whole job and alternates round-robin on contention.

## Interface
- WIDTH, 14, input word width (W and x elements)
- OUT_WIDTH, 28, engine result width
- M, 3, matrix rows = results per job
- N, 3, matrix columns = x length
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- req0_valid / req1_valid  in  1  requester word valid
- req0_ready / req1_ready  out  1  requester word accepted
- req0_data / req1_data  in  WIDTH  requester word
- rsp0_valid / rsp1_valid  out  1  result valid to requester
- rsp0_ready / rsp1_ready  in  1  requester accepts result
- rsp0_data / rsp1_data  out  OUT_WIDTH  result word
- eng_in_valid  out  1  to engine input_valid
- eng_in_ready  in  1  from engine input_ready
- eng_in_data  out  WIDTH  to engine input_data
- eng_out_valid  in  1  from engine output_valid
- eng_out_ready  out  1  to engine output_ready
- eng_out_data  in  OUT_WIDTH  from engine output_data
- busy  out  1  job in progress (state != IDLE)
- owner  out  1  current or last granted port
- job_done  out  1  one-cycle pulse after the final result handshake

## Operation
- Job length: JOB_IN = M*N + N = 12 input words; JOB_OUT = M = 3 results.
- States: IDLE, FEED, DRAIN.
- IDLE: all readies and valids are 0. If any reqX_valid is high, the arbiter grants the port:
  - Both valid: grant the port != last_grant.
  - One valid: grant that port.
  - On grant: owner <= granted port, in_cnt <= 0, go to FEED.
- FEED: the owner's request stream is passed through combinationally to the engine.
  - eng_in_valid = req[owner]_valid; req[owner]_ready = eng_in_ready; eng_in_data = req[owner]_data.
  - The non-owner's ready is 0.
  - Each handshake (eng_in_valid & eng_in_ready) increments in_cnt.
  - On the 12th handshake, out_cnt <= 0 and go to DRAIN.
- DRAIN: the engine output is passed through to the owner.
  - rsp[owner]_valid = eng_out_valid; eng_out_ready = rsp[owner]_ready; rsp[owner]_data = eng_out_data.
  - The non-owner's rsp_valid is 0 and its rsp_data is 0.
  - Each handshake increments out_cnt.
  - On the 3rd handshake: last_grant <= owner, job_done <= 1 next cycle, go to IDLE.
- Outside DRAIN, eng_out_ready = 0. A stray eng_out_valid is held off, not dropped.
- Outside FEED, eng_in_valid = 0 and eng_in_data = 0.
- The non-owner may hold reqX_valid high for the entire job. It is not accepted and not lost.
- Data is never modified; no width conversion.

## Timing
- Reset values: state IDLE, owner 0, last_grant 1 (so port 0 wins the first tie), in_cnt 0, out_cnt 0.
- Output reset values: all readies 0, all valids 0, busy 0, job_done 0.
- Grant latency: 1 cycle. The request seen in IDLE at cycle t becomes ready-able at t+1 in FEED.
- Pass-through latency: 0 cycles (combinational) in FEED and DRAIN.
- Back-to-back jobs: there is at least one IDLE cycle between the last result handshake and the next grant.
- Counter boundary:
  - in_cnt transitions on handshake 12, not on reaching count 11 without a handshake.
  - Stalls (eng_in_ready = 0 or req_valid = 0) hold the counter indefinitely.
- Reset asserted mid-job: immediate abort to the reset values. The engine shares this reset, so no partial job survives.
- No timeout: a DRAIN stalled on rsp_ready holds forever.

## Structure
- Package mvm_arb_pkg holds:
  - state enum (IDLE, FEED, DRAIN)
  - JOB_IN / JOB_OUT localparam functions of M and N
  - counter width = $clog2(JOB_IN+1)
- Sub-module rr_arbiter2 (2 requests, last_grant input, grant output, combinational). It is instantiated once.
- Top-level contents: FSM, counters, owner/last_grant registers, steering muxes.

## Test plan
- Single job on port 0: W = 1..9, x = 1,1,1 → rsp0 receives 6, 15, 24; job_done pulses once; rsp1_valid stays 0.
- Both ports valid at the first IDLE: port 0 is granted (owner = 0) and completes. Port 1 then gets W = identity, x = 5,-3,7 → rsp1 receives 5, -3, 7.
- Contention over 4 jobs with both ports always valid: the grant order is 0, 1, 0, 1, and each port's results match its own job.
- Random 30% bubbles on req_valid, eng_in_ready and rsp_ready: results are unchanged, no word is dropped or duplicated, and in_cnt and out_cnt hit 12 and 3 exactly.
- Reset pulled low during FEED at word 5: within the same cycle all valids and readies are 0 and busy = 0. After release, a fresh job on port 1 completes correctly.
- Engine asserts eng_out_valid during FEED (forced stub): eng_out_ready stays 0 until DRAIN, and the result is delivered intact.
